// File: rtl/hex_display_scanner_4digit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_display_scanner_4digit: multiplexed 4-digit common-anode hex display   |
// | scanner. Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module hex_display_scanner_4digit #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        hold,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int               CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] C_BLANK    = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      snap_val_q, snap_val_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [3:0]       an_n_q, an_n_d;
  logic [6:0]       seg_n_q, seg_n_d;
  logic             dp_n_q, dp_n_d;
  logic             frame_done_q, frame_done_d;

  logic             boundary;
  logic             blank_phase;
  logic             suppress;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    snap_val_d   = snap_val_q;
    snap_dp_d    = snap_dp_q;
    an_n_d       = 4'b1111;
    seg_n_d      = 7'h7F;
    dp_n_d       = 1'b1;
    boundary     = (cnt_q == C_CNT_LAST) && (digit_q == 2'd3);
    blank_phase  = (cnt_q < C_BLANK);
    nibble       = snap_val_q[{digit_q, 2'b00} +: 4];
    suppress     = 1'b0;
    frame_done_d = boundary;

    if (cnt_q == C_CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end

    // Snapshot only at the frame boundary so a frame is never torn
    if (boundary && !hold) begin
      snap_val_d = value;
      snap_dp_d  = dp;
    end

`ifdef LEADING_ZERO_BLANK_EN
    case (digit_q)
      2'd1:    suppress = (snap_val_q[15:4]  == 12'h000) && !snap_dp_q[1];
      2'd2:    suppress = (snap_val_q[15:8]  == 8'h00)   && !snap_dp_q[2];
      2'd3:    suppress = (snap_val_q[15:12] == 4'h0)    && !snap_dp_q[3];
      default: suppress = 1'b0;
    endcase
`else
    suppress = 1'b0;
`endif

    if (!blank_phase && !suppress) begin
      an_n_d  = ~(4'b0001 << digit_q);
      seg_n_d = hex_to_seg(nibble);
      dp_n_d  = ~snap_dp_q[digit_q];
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      snap_val_q   <= 16'h0000;
      snap_dp_q    <= 4'h0;
      an_n_q       <= 4'b1111;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
